// File: rtl/lsu_dmem_ctrl_pkg.sv
// lsu_dmem_ctrl_pkg: memory widths, N_BYTES encodings and load/store controller states
package lsu_dmem_ctrl_pkg;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_WORD_WIDTH = 32;
  localparam logic [1:0] NB_BYTE = 2'd0;
  localparam logic [1:0] NB_HALF = 2'd1;
  localparam logic [1:0] NB_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/mem_read_write.sv
// mem_read_write: data-memory port between a core-side requester and the memory
interface mem_read_write;
  import lsu_dmem_ctrl_pkg::*;
  logic REQ;
  logic WRITE_EN;
  logic [1:0] N_BYTES;
  logic [MEM_ADDR_WIDTH-1:0] ADDR;
  logic [MEM_WORD_WIDTH-1:0] W_DATA;
  logic [MEM_WORD_WIDTH-1:0] R_DATA;
  logic ADDR_ERR;
  modport core_side (output REQ, WRITE_EN, N_BYTES, ADDR, W_DATA, input R_DATA, ADDR_ERR);
  modport mem_side (input REQ, WRITE_EN, N_BYTES, ADDR, W_DATA, output R_DATA, ADDR_ERR);
endinterface

// File: rtl/lsu_dmem_ctrl_load_extend.sv
// lsu_load_extend: sign- or zero-extends right-justified load data to XLEN
module lsu_load_extend
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);
  always_comb
    ext = size == NB_BYTE ? {{(XLEN-8){~uns & raw[7]}}, raw[7:0]} :
          size == NB_HALF ? {{(XLEN-16){~uns & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: aligns, issues and times data-memory accesses, returning one response per op
module lsu_dmem_ctrl
  import lsu_dmem_ctrl_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1,
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]           req_wdata,
  output logic                      rsp_valid,
  output logic [XLEN-1:0]           rsp_rdata,
  output logic                      rsp_err_misalign,
  output logic                      rsp_err_access,
  output logic                      busy,
  mem_read_write.core_side          dmem
);
  lsu_state_t state;
  logic [2:0] cnt;
  logic       uns_q;
  logic       misalign;
  logic [XLEN-1:0] ext;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign misalign = req_size == 2'd3 || (req_size == NB_HALF && req_addr[0]) ||
                    (req_size == NB_WORD && |req_addr[1:0]);
  lsu_load_extend #(.XLEN(XLEN)) u_ext (
    .raw(dmem.R_DATA),
    .size(dmem.N_BYTES),
    .uns(uns_q),
    .ext(ext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      uns_q <= 1'b0;
      dmem.REQ <= 1'b0;
      dmem.WRITE_EN <= 1'b0;
      dmem.N_BYTES <= '0;
      dmem.ADDR <= '0;
      dmem.W_DATA <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err_misalign <= 1'b0;
      rsp_err_access <= 1'b0;
    end else begin
      dmem.REQ <= 1'b0;
      rsp_valid <= 1'b0;
      // the response fields are written in the sampling cycle so they land together with rsp_valid
      if ((state == ACCESS && MEM_RD_LATENCY == 0) || (state == WAIT && cnt == 3'd0)) begin
        rsp_valid <= 1'b1;
        rsp_err_misalign <= 1'b0;
        rsp_err_access <= dmem.ADDR_ERR;
        rsp_rdata <= (dmem.ADDR_ERR || dmem.WRITE_EN) ? '0 : ext;
      end
      unique case (state)
        IDLE: if (req_valid) begin
          if (misalign) begin
            state <= RESP;
            rsp_valid <= 1'b1;
            rsp_err_misalign <= 1'b1;
            rsp_err_access <= 1'b0;
            rsp_rdata <= '0;
          end else begin
            state <= ACCESS;
            dmem.REQ <= 1'b1;
            dmem.WRITE_EN <= req_we;
            dmem.N_BYTES <= req_size;
            dmem.ADDR <= req_addr;
            dmem.W_DATA <= req_wdata;
            uns_q <= req_unsigned;
          end
        end
        ACCESS: begin
          state <= MEM_RD_LATENCY == 0 ? RESP : WAIT;
          cnt <= 3'(MEM_RD_LATENCY - 1);
        end
        WAIT: begin
          state <= cnt == 3'd0 ? RESP : WAIT;
          cnt <= cnt - 3'd1;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl: directed checks of lsu_dmem_ctrl at latencies 0, 1 and 3
module tb_lsu_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] v = '0;
  logic we = 1'b0;
  logic [1:0] size = '0;
  logic uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata = '0;
  logic aerr = 1'b0;
  wire [2:0] ready, rspv, em, ea, busy, reqw;
  wire [31:0] rd [3];
  int nreq [3] = '{0, 0, 0};
  int checks = 0;
  int errors = 0;
  logic [31:0] r_rd;
  logic r_em, r_ea, r_rdy;
  int lat, req_lat, nr;
  logic quiet;

  always #5 clk = ~clk;

  mem_read_write m0 ();
  mem_read_write m1 ();
  mem_read_write m3 ();
  assign m0.R_DATA = rdata;
  assign m1.R_DATA = rdata;
  assign m3.R_DATA = rdata;
  assign m0.ADDR_ERR = aerr;
  assign m1.ADDR_ERR = aerr;
  assign m3.ADDR_ERR = aerr;
  assign reqw = {m3.REQ, m1.REQ, m0.REQ};

  lsu_dmem_ctrl #(.MEM_RD_LATENCY(0)) u0 (.clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(ready[0]),
    .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rspv[0]), .rsp_rdata(rd[0]), .rsp_err_misalign(em[0]), .rsp_err_access(ea[0]),
    .busy(busy[0]), .dmem(m0));
  lsu_dmem_ctrl #(.MEM_RD_LATENCY(1)) u1 (.clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(ready[1]),
    .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rspv[1]), .rsp_rdata(rd[1]), .rsp_err_misalign(em[1]), .rsp_err_access(ea[1]),
    .busy(busy[1]), .dmem(m1));
  lsu_dmem_ctrl #(.MEM_RD_LATENCY(3)) u3 (.clk(clk), .rst(rst), .req_valid(v[2]), .req_ready(ready[2]),
    .req_we(we), .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rspv[2]), .rsp_rdata(rd[2]), .rsp_err_misalign(em[2]), .rsp_err_access(ea[2]),
    .busy(busy[2]), .dmem(m3));

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (reqw[i]) nreq[i] = nreq[i] + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int w, input logic a_we, input logic [1:0] a_size, input logic a_uns,
                       input logic [31:0] a_addr, input logic [31:0] a_wdata, input logic hold);
    int n0;
    @(negedge clk);
    we = a_we; size = a_size; uns = a_uns; addr = a_addr; wdata = a_wdata;
    v[w] = 1'b1;
    n0 = nreq[w];
    lat = 0; req_lat = 0; r_rdy = 1'b0;
    do begin
      @(negedge clk);
      if (!hold) v[w] = 1'b0;
      lat++;
      if (reqw[w] && req_lat == 0) req_lat = lat;
      if (ready[w]) r_rdy = 1'b1;
    end while (!rspv[w] && lat < 20);
    v[w] = 1'b0;
    r_rd = rd[w]; r_em = em[w]; r_ea = ea[w];
    nr = nreq[w] - n0;
    @(negedge clk);
    chk("rsp_one_cycle", {31'd0, rspv[w]}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", {29'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {29'd0, rspv}, 32'd0);
    chk("rst_ready", {29'd0, ready}, 32'd7);
    chk("rst_rdata", rd[1], 32'd0);
    chk("rst_req", {29'd0, reqw}, 32'd0);
    chk("rst_addr", m1.ADDR, 32'd0);
    chk("rst_errs", {30'd0, em[1], ea[1]}, 32'd0);
    rst = 1'b0;

    rdata = 32'hDEADBEEF;
    do_op(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("lw_latency", lat, 3);
    chk("lw_req_cycle", req_lat, 1);
    chk("lw_req_count", nr, 1);
    chk("lw_rdata", r_rd, 32'hDEADBEEF);
    chk("lw_errs", {30'd0, r_em, r_ea}, 32'd0);
    chk("lw_n_bytes", {30'd0, m1.N_BYTES}, 32'd2);
    chk("lw_addr", m1.ADDR, 32'h100);
    chk("lw_write_en", {31'd0, m1.WRITE_EN}, 32'd0);

    rdata = 32'h00000080;
    do_op(1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 1'b0);
    chk("lb_rdata", r_rd, 32'hFFFFFF80);
    do_op(1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1'b0);
    chk("lbu_rdata", r_rd, 32'h00000080);
    rdata = 32'h00008001;
    do_op(1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 1'b0);
    chk("lh_rdata", r_rd, 32'hFFFF8001);
    do_op(1, 1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 1'b0);
    chk("lhu_rdata", r_rd, 32'h00008001);

    rdata = 32'hAAAAAAAA;
    do_op(1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 1'b0);
    chk("lw_mis_latency", lat, 1);
    chk("lw_mis_req_count", nr, 0);
    chk("lw_mis_flags", {30'd0, r_em, r_ea}, 32'd2);
    chk("lw_mis_rdata", r_rd, 32'd0);
    do_op(1, 1'b1, 2'd1, 1'b0, 32'h101, 32'h5555, 1'b0);
    chk("sh_mis_latency", lat, 1);
    chk("sh_mis_req_count", nr, 0);
    chk("sh_mis_flags", {30'd0, r_em, r_ea}, 32'd2);
    do_op(1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 1'b0);
    chk("sz3_latency", lat, 1);
    chk("sz3_flags", {30'd0, r_em, r_ea}, 32'd2);
    chk("sz3_rdata", r_rd, 32'd0);

    aerr = 1'b1;
    do_op(1, 1'b1, 2'd2, 1'b0, 32'h200, 32'h12345678, 1'b0);
    chk("sw_err_flags", {30'd0, r_em, r_ea}, 32'd1);
    chk("sw_err_rdata", r_rd, 32'd0);
    chk("sw_latency", lat, 3);
    chk("sw_write_en", {31'd0, m1.WRITE_EN}, 32'd1);
    chk("sw_w_data", m1.W_DATA, 32'h12345678);
    chk("sw_addr", m1.ADDR, 32'h200);
    rdata = 32'h00005555;
    do_op(1, 1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 1'b0);
    chk("lw_err_flags", {30'd0, r_em, r_ea}, 32'd1);
    chk("lw_err_rdata", r_rd, 32'd0);
    aerr = 1'b0;
    rdata = 32'h0000FFFF;
    do_op(1, 1'b1, 2'd2, 1'b0, 32'h208, 32'h1, 1'b0);
    chk("sw_ok_rdata", r_rd, 32'd0);
    chk("sw_ok_flags", {30'd0, r_em, r_ea}, 32'd0);

    rdata = 32'hCAFEF00D;
    do_op(0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 1'b1);
    chk("l0_latency", lat, 2);
    chk("l0_ready_low", {31'd0, r_rdy}, 32'd0);
    chk("l0_req_count", nr, 1);
    chk("l0_rdata", r_rd, 32'hCAFEF00D);
    do_op(2, 1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 1'b1);
    chk("l3_latency", lat, 5);
    chk("l3_req_cycle", req_lat, 1);
    chk("l3_ready_low", {31'd0, r_rdy}, 32'd0);
    chk("l3_req_count", nr, 1);
    chk("l3_rdata", r_rd, 32'hCAFEF00D);

    @(negedge clk);
    we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h400;
    v[2] = 1'b1;
    @(negedge clk);
    v[2] = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'd0, busy[2]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy[2]}, 32'd0);
    chk("mid_rst_req", {31'd0, reqw[2]}, 32'd0);
    quiet = 1'b1;
    repeat (6) begin
      if (rspv[2]) quiet = 1'b0;
      @(negedge clk);
    end
    chk("mid_rst_no_rsp", {31'd0, quiet}, 32'd1);
    rdata = 32'h0BADF00D;
    do_op(2, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 1'b0);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_rdata", r_rd, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
